// File: rtl/mem_interface_pkg.sv
// Shared constants and state encoding for the memory interface controller.
// Data width, default address width and default ack timeout live here.
package mem_interface_pkg;

  localparam int DATA_W          = 32;
  localparam int ADDR_W_DEFAULT  = 9;
  localparam int TIMEOUT_DEFAULT = 15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  // Wait-counter width: must hold values up to timeout-1.
  function automatic int cnt_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/register32.sv
// Shared 32-bit data register with load enable and asynchronous active-low clear.
import mem_interface_pkg::*;

module register32 (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/mem_interface.sv
// MAR/MDR front end that runs single read/write handshakes against memory,
// with an ack timeout and one-cycle Done/Error completion pulses.
import mem_interface_pkg::*;

module mem_interface #(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] BusMuxIn_MDR,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  localparam int CNT_W = cnt_width(TIMEOUT);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              idle, start, timed_out;
  logic              mdr_en;
  logic [DATA_W-1:0] mdr_d;

  assign idle      = (state == S_IDLE);
  assign start     = idle && (Read || Write);
  assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of a combinational block is defaulted first, so no
  // path through the case can leave a value held and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (Read || Write) state_next = S_REQ;
      S_REQ: begin
        if (mem_ack)        state_next = S_DONE;
        else if (timed_out) state_next = S_ERR;
      end
      S_DONE:  state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Read wins over Write; the direction is frozen for the whole transaction.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt    <= '0;
      mem_we <= 1'b0;
      mar    <= '0;
    end else begin
      if (start) begin
        cnt    <= '0;
        mem_we <= !Read;
      end else if (state == S_REQ) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (idle && MARin && !Read && !Write) mar <= BusMuxOut[ADDR_W-1:0];
    end
  end

  // MDR loads from the bus only in a quiet IDLE cycle, or from memory on a read ack.
  always_comb begin
    mdr_en = 1'b0;
    mdr_d  = BusMuxOut;
    if (idle && MDRin && !Read && !Write) begin
      mdr_en = 1'b1;
    end else if (state == S_REQ && mem_ack && !mem_we) begin
      mdr_en = 1'b1;
      mdr_d  = mem_rdata;
    end
  end

  register32 u_mdr (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (mdr_en),
    .d     (mdr_d),
    .q     (mdr)
  );

  assign mem_req      = (state == S_REQ);
  assign Busy         = mem_req;
  assign Done         = (state == S_DONE);
  assign Error        = (state == S_ERR);
  assign mem_addr     = mar;
  assign mem_wdata    = mdr;
  assign BusMuxIn_MDR = mdr;

endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface: read, write, timeout, priority, reset abort,
// last-cycle ack and stray ack, each with hand-computed expectations.
module tb_mem_interface;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [31:0] BusMuxOut;
  logic        MARin, MDRin, Read, Write;
  logic [31:0] BusMuxIn_MDR;
  logic        mem_req, mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        Busy, Done, Error;

  int checks = 0;
  int errors = 0;

  mem_interface #(.ADDR_W(9), .TIMEOUT(15)) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .BusMuxOut    (BusMuxOut),
    .MARin        (MARin),
    .MDRin        (MDRin),
    .Read         (Read),
    .Write        (Write),
    .BusMuxIn_MDR (BusMuxIn_MDR),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .Busy         (Busy),
    .Done         (Done),
    .Error        (Error)
  );

  always #5 clk = ~clk;

  // Advance one clock edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0; BusMuxOut = '0; MARin = 0; MDRin = 0; Read = 0; Write = 0;
    mem_rdata = '0; mem_ack = 0;
    tick(); tick();
    checks++;
    if ({mem_req, mem_we, Busy, Done, Error} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000", {mem_req, mem_we, Busy, Done, Error});
    end
    checks++;
    if (BusMuxIn_MDR !== 32'h0 || mem_addr !== 9'h0) begin
      errors++; $display("FAIL reset_regs got mdr=%h addr=%h exp 0/0", BusMuxIn_MDR, mem_addr);
    end
    clr_n = 1'b1;
    tick();
  endtask

  task automatic test_read();
    BusMuxOut = 32'h0000_0012; MARin = 1; tick(); MARin = 0;
    checks++;
    if (mem_addr !== 9'h012) begin
      errors++; $display("FAIL read_mar got %h exp 012", mem_addr);
    end
    Read = 1; tick(); Read = 0;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || Busy !== 1'b1) begin
      errors++; $display("FAIL read_req got req=%b we=%b busy=%b exp 1/0/1", mem_req, mem_we, Busy);
    end
    tick(); tick();
    mem_ack = 1; mem_rdata = 32'hDEAD_BEEF; tick(); mem_ack = 0; mem_rdata = '0;
    checks++;
    if (Done !== 1'b1 || mem_req !== 1'b0 || BusMuxIn_MDR !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL read_done got done=%b req=%b mdr=%h exp 1/0/deadbeef", Done, mem_req, BusMuxIn_MDR);
    end
    tick();
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0 || BusMuxIn_MDR !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL read_after got done=%b busy=%b mdr=%h exp 0/0/deadbeef", Done, Busy, BusMuxIn_MDR);
    end
  endtask

  task automatic test_write();
    BusMuxOut = 32'h0000_00A5; MDRin = 1; tick(); MDRin = 0;
    checks++;
    if (BusMuxIn_MDR !== 32'hA5) begin
      errors++; $display("FAIL write_mdrin got %h exp 000000a5", BusMuxIn_MDR);
    end
    Write = 1; tick(); Write = 0;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hA5) begin
      errors++; $display("FAIL write_req got req=%b we=%b wdata=%h exp 1/1/000000a5", mem_req, mem_we, mem_wdata);
    end
    mem_ack = 1; mem_rdata = 32'h1111_1111; tick(); mem_ack = 0; mem_rdata = '0;
    checks++;
    if (Done !== 1'b1 || BusMuxIn_MDR !== 32'hA5) begin
      errors++; $display("FAIL write_done got done=%b mdr=%h exp 1/000000a5", Done, BusMuxIn_MDR);
    end
    tick();
    checks++;
    if (Done !== 1'b0 || Error !== 1'b0) begin
      errors++; $display("FAIL write_pulse got done=%b err=%b exp 0/0", Done, Error);
    end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    int err_pulses = 0;
    int done_pulses = 0;
    Read = 1; tick(); Read = 0;
    for (int i = 0; i < 25; i++) begin
      if (mem_req) req_cycles++;
      if (Error) err_pulses++;
      if (Done) done_pulses++;
      tick();
    end
    checks++;
    if (req_cycles != 15) begin
      errors++; $display("FAIL timeout_req_cycles got %0d exp 15", req_cycles);
    end
    checks++;
    if (err_pulses != 1 || done_pulses != 0) begin
      errors++; $display("FAIL timeout_pulses got err=%0d done=%0d exp 1/0", err_pulses, done_pulses);
    end
    checks++;
    if (BusMuxIn_MDR !== 32'hA5 || Busy !== 1'b0) begin
      errors++; $display("FAIL timeout_mdr got mdr=%h busy=%b exp 000000a5/0", BusMuxIn_MDR, Busy);
    end
  endtask

  task automatic test_priority();
    Read = 1; Write = 1; MDRin = 1; BusMuxOut = 32'h5555_5555; tick();
    Read = 0; Write = 0;
    checks++;
    if (mem_we !== 1'b0 || mem_req !== 1'b1 || BusMuxIn_MDR !== 32'hA5) begin
      errors++; $display("FAIL prio_start got we=%b req=%b mdr=%h exp 0/1/000000a5", mem_we, mem_req, BusMuxIn_MDR);
    end
    MDRin = 1; MARin = 1; BusMuxOut = 32'hFFFF_FFFF; tick();
    checks++;
    if (BusMuxIn_MDR !== 32'hA5 || mem_addr !== 9'h012) begin
      errors++; $display("FAIL prio_busy_load got mdr=%h addr=%h exp 000000a5/012", BusMuxIn_MDR, mem_addr);
    end
    mem_ack = 1; mem_rdata = 32'h0BAD_F00D; tick();
    mem_ack = 0; MDRin = 0; MARin = 0; BusMuxOut = '0;
    checks++;
    if (Done !== 1'b1 || BusMuxIn_MDR !== 32'h0BAD_F00D || mem_addr !== 9'h012) begin
      errors++; $display("FAIL prio_done got done=%b mdr=%h addr=%h exp 1/0badf00d/012", Done, BusMuxIn_MDR, mem_addr);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    Read = 1; tick(); Read = 0; tick();
    #2 clr_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, Busy, Done, Error} !== 5'b0 || BusMuxIn_MDR !== 32'h0 || mem_addr !== 9'h0) begin
      errors++; $display("FAIL abort_outputs got ctrl=%b mdr=%h addr=%h exp 0/0/0",
                         {mem_req, mem_we, Busy, Done, Error}, BusMuxIn_MDR, mem_addr);
    end
    @(posedge clk); #3 clr_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (Done || Error || mem_req) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL abort_pulses got %0d active cycles exp 0", pulses);
    end
  endtask

  task automatic test_last_cycle_ack();
    Read = 1; tick(); Read = 0;
    repeat (14) tick();
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL last_still_req got %b exp 1", mem_req);
    end
    mem_ack = 1; mem_rdata = 32'h1234_5678; tick(); mem_ack = 0; mem_rdata = '0;
    checks++;
    if (Done !== 1'b1 || Error !== 1'b0 || BusMuxIn_MDR !== 32'h1234_5678) begin
      errors++; $display("FAIL last_ack got done=%b err=%b mdr=%h exp 1/0/12345678", Done, Error, BusMuxIn_MDR);
    end
    tick();
    checks++;
    if (Error !== 1'b0 || Done !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL last_after got err=%b done=%b busy=%b exp 0/0/0", Error, Done, Busy);
    end
  endtask

  task automatic test_stray_ack();
    mem_ack = 1; mem_rdata = 32'hCAFE_F00D; tick(); mem_ack = 0; mem_rdata = '0;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Error !== 1'b0 || BusMuxIn_MDR !== 32'h1234_5678) begin
      errors++; $display("FAIL stray_ack got busy=%b done=%b err=%b mdr=%h exp 0/0/0/12345678",
                         Busy, Done, Error, BusMuxIn_MDR);
    end
    tick();
    checks++;
    if (Done !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL stray_after got done=%b req=%b exp 0/0", Done, mem_req);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_priority();
    test_reset_abort();
    test_last_cycle_ack();
    test_stray_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_interface.md
MEM_INTERFACE -- requirements
Module: mem_interface

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, memory address width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum number of cycles to wait for mem_ack.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port clr_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port BusMuxOut, input, 32 bits: value currently driven on the datapath bus.
REQ-006 SHALL have port MARin, input, 1 bit: load MAR from BusMuxOut[ADDR_W-1:0].
REQ-007 SHALL have port MDRin, input, 1 bit: load MDR from BusMuxOut.
REQ-008 SHALL have port Read, input, 1 bit: start a memory read at address MAR.
REQ-009 SHALL have port Write, input, 1 bit: start a memory write of MDR to address MAR.
REQ-010 SHALL have port BusMuxIn_MDR, output, 32 bits: MDR contents, feeding the bus multiplexer MDR input.
REQ-011 SHALL have port mem_req, output, 1 bit: memory request, held high until acknowledged or timed out.
REQ-012 SHALL have port mem_we, output, 1 bit: 1 = write, 0 = read; valid while mem_req is high.
REQ-013 SHALL have port mem_addr, output, ADDR_W bits: equal to MAR at all times.
REQ-014 SHALL have port mem_wdata, output, 32 bits: equal to MDR at all times.
REQ-015 SHALL have port mem_rdata, input, 32 bits: read data, valid in the cycle mem_ack is high.
REQ-016 SHALL have port mem_ack, input, 1 bit: single-cycle completion strobe from memory.
REQ-017 SHALL have port Busy, output, 1 bit: high in the REQ state.
REQ-018 SHALL have port Done, output, 1 bit: one-cycle pulse on successful completion.
REQ-019 SHALL have port Error, output, 1 bit: one-cycle pulse on timeout.

Function
REQ-020 SHALL implement an FSM with states IDLE, REQ, DONE and ERR.
REQ-021 In IDLE, Read SHALL latch mem_we=0 and go to REQ on the next edge; Read SHALL take priority over a simultaneous Write.
REQ-022 In IDLE, Write without Read SHALL latch mem_we=1 and go to REQ on the next edge.
REQ-023 In REQ, mem_req SHALL be 1 and the wait counter SHALL increment by 1 each cycle, starting from 0.
REQ-024 In REQ with mem_ack=1 on a read, MDR SHALL load mem_rdata at that edge; the FSM SHALL go to DONE.
REQ-025 In REQ with mem_ack=1 on a write, MDR SHALL be unchanged; the FSM SHALL go to DONE.
REQ-026 In REQ with mem_ack=0 and counter = TIMEOUT-1, the FSM SHALL go to ERR; MDR SHALL be unchanged.
REQ-027 mem_ack arriving in the same cycle the counter reaches TIMEOUT-1 SHALL count as success.
REQ-028 DONE and ERR SHALL each last one cycle, asserting Done or Error respectively, then return to IDLE.
REQ-029 mem_ack outside REQ SHALL be ignored.
REQ-030 MARin and MDRin SHALL take effect only in IDLE and SHALL be ignored in all other states.
REQ-031 In IDLE, MDRin asserted together with Read or Write SHALL be ignored (the transaction wins); MARin together with Read or Write SHALL be ignored.
REQ-032 Read and Write outside IDLE SHALL be ignored; they are not queued.
REQ-033 Minimum read latency SHALL be: Read at edge N, mem_req high from N+1, ack at N+1, MDR valid and Done high from N+2.

Reset
REQ-034 While clr_n=0: state=IDLE, MAR=0, MDR=0, counter=0, mem_we=0, mem_req=0, Busy=0, Done=0, Error=0.
REQ-035 Reset asserted mid-transaction SHALL abort it immediately (mem_req low asynchronously), with no Done or Error pulse.

Structure
REQ-036 The state encoding and the TIMEOUT default SHALL reside in a shared package with the other datapath constants.
REQ-037 The MAR and MDR SHALL reuse the team's existing 32-bit register sub-module, named register32, for MDR.

Verification
REQ-038 The bench SHALL cover: MARin with BusMuxOut=0x0000_0012, Read, ack after 3 cycles with rdata=0xDEAD_BEEF -> mem_addr=0x012, BusMuxIn_MDR=0xDEAD_BEEF, Done for one cycle.
REQ-039 The bench SHALL cover: MDRin with 0x0000_00A5, Write, immediate ack -> mem_we=1, mem_wdata=0xA5, MDR unchanged, Done after 2 cycles.
REQ-040 The bench SHALL cover: Read with no ack and TIMEOUT=15 -> mem_req high for exactly 15 cycles, Error pulses once, MDR retains its prior value.
REQ-041 The bench SHALL cover: Read and Write high together in IDLE -> mem_we=0; MDRin=1 while Busy with BusMuxOut=0xFFFF_FFFF -> MDR unchanged.
REQ-042 The bench SHALL cover: clr_n low for one cycle during REQ -> mem_req=0 immediately, all outputs 0, no Done or Error pulse.
REQ-043 The bench SHALL cover: ack in the final timeout cycle -> Done and no Error; a stray mem_ack while in IDLE -> no state change.
